// File: rtl/sram_ctrl_param_if.sv
// Host-side bus of sram_ctrl_param: request inputs plus registered read response.
// Handshake: a request (wrEn or rdEn) is taken on a rising edge where ready is 1; ready stays 0 until the access and recovery end; rdValid is a one-cycle pulse that qualifies readData.
interface sram_ctrl_param_if #(parameter int DATA_W = 32);
  logic                  wrEn;
  logic                  rdEn;
  logic [31:0]           address;
  logic [DATA_W-1:0]     writeData;
  logic [DATA_W/8-1:0]   wrStrb;
  logic [DATA_W-1:0]     readData;
  logic                  rdValid;
  logic                  ready;

  modport master (output wrEn, rdEn, address, writeData, wrStrb,
                  input  readData, rdValid, ready);
  modport slave  (input  wrEn, rdEn, address, writeData, wrStrb,
                  output readData, rdValid, ready);
endinterface

// File: rtl/sram_ctrl_param.sv
// Host-word to 16-bit asynchronous SRAM controller: multi-beat writes and reads,
// followed by a fixed recovery period.
module sram_ctrl_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_param_if.slave  bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [1:0]        state_dbg
);
  localparam int NB     = DATA_W / 16;
  localparam int BEAT_W = 3;
  localparam logic [BEAT_W-1:0] LAST_WR   = BEAT_W'(NB - 1);
  localparam logic [BEAT_W-1:0] LAST_RD   = BEAT_W'(NB);
  localparam logic [3:0]        WAIT_LOAD = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [31:0]       BASE      = 32'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, RECOVER = 2'd3} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q, rbuf_q, rbuf_nxt, rdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [3:0]          wait_q;
  logic                rvalid_q;
  logic                accept, wr_done, rd_done, dq_oe;
  logic [15:0]         dq_out;

  assign accept  = (state == IDLE) && (bus.wrEn || bus.rdEn);
  assign wr_done = (state == WRITE) && (beat_q == LAST_WR);
  assign rd_done = (state == READ) && (beat_q == LAST_RD);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write wins over a simultaneous read; the read is simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.wrEn) state_nxt = WRITE;
               else if (bus.rdEn) state_nxt = READ;
      WRITE:   if (wr_done) state_nxt = (WAIT_CYC == 0) ? IDLE : RECOVER;
      READ:    if (rd_done) state_nxt = (WAIT_CYC == 0) ? IDLE : RECOVER;
      RECOVER: if (wait_q == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read beat j lands in buffer slot j-1 (SRAM data trails the address by one cycle).
  always_comb begin
    rbuf_nxt = rbuf_q;
    if (state == READ) begin
      for (int k = 0; k < NB; k++)
        if (beat_q == BEAT_W'(k + 1)) rbuf_nxt[16*k +: 16] = SRAM_DQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      beat_q   <= '0;
      wait_q   <= '0;
    end else begin
      rvalid_q <= rd_done;
      rbuf_q   <= rbuf_nxt;
      if (rd_done) rdata_q <= rbuf_nxt;
      if (accept) begin
        base_q  <= ADDR_W'((bus.address - BASE) >> 1);
        wdata_q <= bus.writeData;
        strb_q  <= bus.wrStrb;
      end
      if (state == WRITE || state == READ) beat_q <= beat_q + BEAT_W'(1);
      else                                 beat_q <= '0;
      if (wr_done || rd_done)   wait_q <= WAIT_LOAD;
      else if (state == RECOVER) wait_q <= wait_q - 4'd1;
    end
  end

  // Reset forces idle pin values combinationally so an aborted beat never reaches the SRAM.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    if (!rst) begin
      case (state)
        WRITE: begin
          SRAM_ADDR = base_q + ADDR_W'(beat_q);
          SRAM_WE_N = 1'b0;
          dq_oe     = 1'b1;
          for (int k = 0; k < NB; k++) begin
            if (beat_q == BEAT_W'(k)) begin
              dq_out    = wdata_q[16*k +: 16];
              SRAM_LB_N = ~strb_q[2*k];
              SRAM_UB_N = ~strb_q[2*k+1];
            end
          end
        end
        READ: begin
          SRAM_ADDR = base_q + ADDR_W'(beat_q);
          SRAM_OE_N = 1'b0;
          SRAM_UB_N = 1'b0;
          SRAM_LB_N = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign SRAM_DQ      = dq_oe ? dq_out : 16'bz;
  assign SRAM_CE_N    = rst;
  assign bus.ready    = (state == IDLE) || rst;
  assign bus.readData = rdata_q;
  assign bus.rdValid  = rvalid_q;
  assign state_dbg    = state;
endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: 32-bit instance with random traffic and a word-level
// memory model, plus a 64-bit instance (no recovery) for wide write/read-back.
module tb_sram_ctrl_param;
  localparam int AW    = 18;
  localparam int AMASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- 32-bit instance ----------------
  sram_ctrl_param_if #(.DATA_W(32)) bus32 ();
  wire  [15:0]   dq32;
  logic [AW-1:0] addr32;
  logic          we32_n, oe32_n, ce32_n, ub32_n, lb32_n;
  logic [1:0]    st32;

  sram_ctrl_param #(.DATA_W(32), .ADDR_W(AW), .BASE_ADDR(1024), .WAIT_CYC(2)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32), .SRAM_DQ(dq32), .SRAM_ADDR(addr32),
    .SRAM_WE_N(we32_n), .SRAM_OE_N(oe32_n), .SRAM_CE_N(ce32_n),
    .SRAM_UB_N(ub32_n), .SRAM_LB_N(lb32_n), .state_dbg(st32));

  // ---------------- 64-bit instance ----------------
  sram_ctrl_param_if #(.DATA_W(64)) bus64 ();
  wire  [15:0]   dq64;
  logic [AW-1:0] addr64;
  logic          we64_n, oe64_n, ce64_n, ub64_n, lb64_n;
  logic [1:0]    st64;

  sram_ctrl_param #(.DATA_W(64), .ADDR_W(AW), .BASE_ADDR(1024), .WAIT_CYC(0)) dut64 (
    .clk(clk), .rst(rst), .bus(bus64), .SRAM_DQ(dq64), .SRAM_ADDR(addr64),
    .SRAM_WE_N(we64_n), .SRAM_OE_N(oe64_n), .SRAM_CE_N(ce64_n),
    .SRAM_UB_N(ub64_n), .SRAM_LB_N(lb64_n), .state_dbg(st64));

  // ---------------- pin-level SRAM models (data returned one cycle after address) ----------------
  logic [15:0] pin_mem32 [0:AMASK];
  logic [15:0] pin_mem64 [0:AMASK];
  logic [15:0] pin_rd32, pin_rd64;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic lb_n, input logic ub_n);
    return {ub_n ? old[15:8] : d[15:8], lb_n ? old[7:0] : d[7:0]};
  endfunction

  always @(posedge clk) begin
    if (!ce32_n && !we32_n) pin_mem32[addr32] <= merge(pin_mem32[addr32], dq32, lb32_n, ub32_n);
    if (!ce64_n && !we64_n) pin_mem64[addr64] <= merge(pin_mem64[addr64], dq64, lb64_n, ub64_n);
    pin_rd32 <= pin_mem32[addr32];
    pin_rd64 <= pin_mem64[addr64];
  end

  assign dq32 = (!oe32_n && we32_n) ? pin_rd32 : 16'hzzzz;
  assign dq64 = (!oe64_n && we64_n) ? pin_rd64 : 16'hzzzz;

  // ---------------- word-level reference model ----------------
  logic [15:0] ref_mem [int unsigned];

  function automatic logic [15:0] ref_get(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 16'h0000;
  endfunction

  function automatic void ref_write(input int unsigned w, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] v;
    v = ref_get(w);
    if (s[0]) v[7:0]  = d[7:0];
    if (s[1]) v[15:8] = d[15:8];
    ref_mem[w] = v;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] addr, input int k);
    return (((addr - 32'd1024) >> 1) + k) & AMASK;
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp_q[$];
  logic [35:0] wbeat_q[$];
  logic [17:0] rd_addr_q[$];
  logic [63:0] exp64_q[$];
  logic [31:0] rd_hold32 = '0;
  int          rd_j32 = 0;

  // ---------------- monitor: 32-bit instance ----------------
  initial begin
    logic [35:0] eb;
    logic [17:0] ea;
    logic [31:0] ed;
    forever begin
      @(negedge clk); #1;
      check("ce_n", ce32_n, rst);
      if (rst || (we32_n && oe32_n))
        check("idle_pins", {addr32, we32_n, oe32_n, ub32_n, lb32_n}, {18'h0, 4'hF});
      if (rst) begin
        check("rst_ready", bus32.ready, 1'b1);
        rd_j32 = 0;
      end else begin
        if (!we32_n) begin
          if (wbeat_q.size() == 0) check("unexpected_wr_beat", 1, 0);
          else begin
            eb = wbeat_q.pop_front();
            check("wr_beat", {addr32, dq32, lb32_n, ub32_n, oe32_n}, {eb, 1'b1});
          end
        end
        if (!oe32_n) begin
          check("rd_ctl", {we32_n, ub32_n, lb32_n}, 3'b100);
          if (rd_j32 < 2) begin
            if (rd_addr_q.size() == 0) check("unexpected_rd_beat", 1, 0);
            else begin
              ea = rd_addr_q.pop_front();
              check("rd_addr", addr32, ea);
            end
          end
          rd_j32++;
        end else rd_j32 = 0;
        if (bus32.rdValid) begin
          if (exp_q.size() == 0) check("unexpected_rdvalid", 1, 0);
          else begin
            ed = exp_q.pop_front();
            check("rd_data", bus32.readData, ed);
            rd_hold32 = ed;
          end
        end
        check("rd_hold", bus32.readData, rd_hold32);
      end
    end
  end

  // ---------------- monitor: 64-bit instance ----------------
  initial begin
    logic [63:0] ed;
    forever begin
      @(negedge clk); #1;
      if (!rst && bus64.rdValid) begin
        if (exp64_q.size() == 0) check("unexpected_rdvalid64", 1, 0);
        else begin
          ed = exp64_q.pop_front();
          check("rd_data64", bus64.readData, ed);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle32();
    int n;
    n = 0;
    while (!bus32.ready && n < 200) begin @(negedge clk); n++; end
    if (!bus32.ready) check("ready_timeout32", 0, 1);
  endtask

  task automatic issue32(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    int unsigned w;
    int cyc;
    wait_idle32();
    if (wr) begin
      for (int k = 0; k < 2; k++) begin
        w = word_of(addr, k);
        wbeat_q.push_back({18'(w), data[16*k +: 16], ~strb[2*k], ~strb[2*k+1]});
        ref_write(w, data[16*k +: 16], strb[2*k +: 2]);
      end
    end else if (rd) begin
      exp_q.push_back({ref_get(word_of(addr, 1)), ref_get(word_of(addr, 0))});
      rd_addr_q.push_back(18'(word_of(addr, 0)));
      rd_addr_q.push_back(18'(word_of(addr, 1)));
    end
    bus32.wrEn = wr; bus32.rdEn = rd;
    bus32.address = addr; bus32.writeData = data; bus32.wrStrb = strb;
    @(negedge clk);
    bus32.wrEn = 1'b0; bus32.rdEn = 1'b0;
    bus32.address = $urandom(); bus32.writeData = $urandom(); bus32.wrStrb = 4'($urandom_range(0, 15));
    cyc = 0;
    while (!bus32.ready && cyc < 200) begin @(negedge clk); cyc++; end
    if (wr) check("wr_busy", cyc, 4);
    else    check("rd_busy", cyc, 5);
  endtask

  task automatic reset_abort32(input logic [31:0] addr);
    wait_idle32();
    rd_addr_q.push_back(18'(word_of(addr, 0)));
    bus32.rdEn = 1'b1; bus32.address = addr;
    @(negedge clk);
    bus32.rdEn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_comb_ready", bus32.ready, 1'b1);
    check("abort_comb_pins", {we32_n, oe32_n, ub32_n, lb32_n}, 4'hF);
    @(posedge clk);
    rd_hold32 = '0;
    @(negedge clk); #2;
    check("abort_state", st32, 2'd0);
    check("abort_ready", bus32.ready, 1'b1);
    check("abort_rdata", bus32.readData, 32'h0);
    check("abort_rdvalid", bus32.rdValid, 1'b0);
    rst = 1'b0;
    rd_addr_q.delete();
  endtask

  task automatic issue64(input bit wr, input logic [31:0] addr, input logic [63:0] data,
                         input logic [7:0] strb);
    int cyc;
    cyc = 0;
    while (!bus64.ready && cyc < 200) begin @(negedge clk); cyc++; end
    if (!wr) exp64_q.push_back(data);
    bus64.wrEn = wr; bus64.rdEn = !wr;
    bus64.address = addr; bus64.writeData = data; bus64.wrStrb = strb;
    @(negedge clk);
    bus64.wrEn = 1'b0; bus64.rdEn = 1'b0;
    bus64.address = $urandom(); bus64.writeData = {$urandom(), $urandom()};
    cyc = 0;
    while (!bus64.ready && cyc < 200) begin @(negedge clk); cyc++; end
    if (wr) check("wr_busy64", cyc, 4);
    else    check("rd_busy64", cyc, 5);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a, d;
    int sel;
    for (int i = 0; i <= AMASK; i++) begin pin_mem32[i] = '0; pin_mem64[i] = '0; end
    // Requests held during reset must be ignored.
    bus32.wrEn = 1'b1; bus32.rdEn = 1'b1; bus32.address = 32'd1024;
    bus32.writeData = 32'h1234_5678; bus32.wrStrb = 4'hF;
    bus64.wrEn = 1'b1; bus64.rdEn = 1'b0; bus64.address = 32'd1024;
    bus64.writeData = 64'h1; bus64.wrStrb = 8'hFF;
    #1;
    check("rst_comb_ready", bus32.ready, 1'b1);
    check("rst_comb_pins", {addr32, we32_n, oe32_n, ub32_n, lb32_n}, {18'h0, 4'hF});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus32.wrEn = 1'b0; bus32.rdEn = 1'b0;
    bus64.wrEn = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_rdata", bus32.readData, 32'h0);

    issue32(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 4'hF);
    issue32(1'b0, 1'b1, 32'd1024, 32'h0, 4'h0);
    issue32(1'b1, 1'b0, 32'd1024 + 2 * AMASK, 32'hA5C3_9E17, 4'h6);
    issue32(1'b0, 1'b1, 32'd1024 + 2 * AMASK, 32'h0, 4'h0);
    issue32(1'b1, 1'b1, 32'd1032, 32'h5555_AAAA, 4'hF);
    issue32(1'b1, 1'b0, 32'd1036, 32'hFFFF_FFFF, 4'h0);
    issue32(1'b0, 1'b1, 32'd1032, 32'h0, 4'h0);
    reset_abort32(32'd1024);
    issue32(1'b0, 1'b1, 32'd1024, 32'h0, 4'h0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 32'd1024 + 2 * $urandom_range(0, 15) + $urandom_range(0, 1);
      else if (sel < 8) a = 32'd1024 + 2 * (AMASK - $urandom_range(0, 1));
      else              a = $urandom();
      d = $urandom();
      sel = $urandom_range(0, 9);
      if (sel < 5)      issue32(1'b1, 1'b0, a, d, 4'($urandom_range(0, 15)));
      else if (sel < 9) issue32(1'b0, 1'b1, a, d, 4'h0);
      else              issue32(1'b1, 1'b1, a, d, 4'($urandom_range(0, 15)));
    end

    issue64(1'b1, 32'd1024 + 2 * 100, 64'h0123_4567_89AB_CDEF, 8'hFF);
    check("mem64_w0", pin_mem64[100], 16'hCDEF);
    check("mem64_w1", pin_mem64[101], 16'h89AB);
    check("mem64_w2", pin_mem64[102], 16'h4567);
    check("mem64_w3", pin_mem64[103], 16'h0123);
    issue64(1'b0, 32'd1024 + 2 * 100, 64'h0123_4567_89AB_CDEF, 8'h00);

    wait_idle32();
    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("wbeat_q_drained", wbeat_q.size(), 0);
    check("rd_addr_q_drained", rd_addr_q.size(), 0);
    check("exp64_q_drained", exp64_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
